// File: rtl/riscv_defs.sv
// riscv_defs: shared FSM encodings and constants for the fetch path
package riscv_defs;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, ISSUE = 2'd2} state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0100;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC priority mux (jalr > branch > pc+4) with misalignment check
module pc_next_sel (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jalr_taken,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc,
    output logic        misalign
);
    logic [31:0] jalr_pc;
    assign jalr_pc = jalr_target & ~32'd1;
    assign next_pc = jalr_taken ? jalr_pc : branch_taken ? branch_target : pc + 32'd4;
    // a dropped branch never traps when jalr wins
    assign misalign = jalr_taken ? jalr_target[1] : branch_taken & (|branch_target[1:0]);
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and single-outstanding instruction fetch sequencer
module pc_fetch_unit
    import riscv_defs::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jalr_taken,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_exc
);
    state_t state, state_nx;
    logic [31:0] next_pc;
    logic misalign, issue_go;

    pc_next_sel u_sel (
        .pc(pc),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jalr_taken(jalr_taken),
        .jalr_target(jalr_target),
        .next_pc(next_pc),
        .misalign(misalign)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? FETCH :
                   state == FETCH ? (imem_ack ? ISSUE : FETCH) :
                   state == ISSUE ? (stall ? ISSUE : FETCH) : IDLE;
    end

    // combinational so an asynchronous reset drops the request at once
    assign imem_req = state == FETCH;
    assign imem_addr = pc;
    assign issue_go = state == ISSUE && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
            instr_pc <= RESET_VECTOR;
            instr <= NOP;
            instr_valid <= 1'b0;
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= issue_go && misalign;
            if (state == FETCH && imem_ack) begin
                instr <= imem_rdata;
                instr_pc <= pc;
                instr_valid <= 1'b1;
            end
            if (issue_go) begin
                pc <= misalign ? TRAP_VECTOR : next_pc;
                instr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jalr_taken = 1'b0;
    logic [31:0] jalr_target = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign_exc;
    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jalr_taken(jalr_taken), .jalr_target(jalr_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, a);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic chk_issue(input string tag, input logic [31:0] a, input logic [31:0] w);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_ipc"}, instr_pc, a);
        chk({tag, "_pc"}, pc, a);
        chk({tag, "_instr"}, instr, w);
    endtask

    initial begin
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_exc", {31'd0, misalign_exc}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_1111;
        rst_n = 1'b1;
        step(); chk_fetch("f0", 32'h0);
        step(); chk_issue("i0", 32'h0, 32'h1111_1111);
        imem_rdata = 32'h2222_2222;
        step(); chk_fetch("f4", 32'h4);
        step(); chk_issue("i4", 32'h4, 32'h2222_2222);
        step(); chk_fetch("f8", 32'h8);
        step(); chk_issue("i8", 32'h8, 32'h2222_2222);
        step(); chk_fetch("fc", 32'hC);
        step(); chk_issue("ic", 32'hC, 32'h2222_2222);
        branch_taken = 1'b1; branch_target = 32'h4;
        step(); chk_fetch("br", 32'h4);
        chk("br_exc", {31'd0, misalign_exc}, 32'd0);
        branch_taken = 1'b0;
        step(); chk_issue("br_i", 32'h4, 32'h2222_2222);
        jalr_taken = 1'b1; jalr_target = 32'h21;
        branch_taken = 1'b1; branch_target = 32'h40;
        step(); chk_fetch("jb", 32'h20);
        chk("jb_exc", {31'd0, misalign_exc}, 32'd0);
        jalr_taken = 1'b0; branch_taken = 1'b0;
        step(); chk_issue("jb_i", 32'h20, 32'h2222_2222);
        branch_taken = 1'b1; branch_target = 32'h16;
        step(); chk_fetch("mis_a", 32'h100);
        chk("mis_a_exc", {31'd0, misalign_exc}, 32'd1);
        branch_taken = 1'b0;
        step(); chk_issue("mis_a_i", 32'h100, 32'h2222_2222);
        chk("mis_a_exc_low", {31'd0, misalign_exc}, 32'd0);
        jalr_taken = 1'b1; jalr_target = 32'h6;
        step(); chk_fetch("mis_b", 32'h100);
        chk("mis_b_exc", {31'd0, misalign_exc}, 32'd1);
        jalr_taken = 1'b0;
        imem_rdata = 32'h3333_3333;
        step(); chk_issue("mis_b_i", 32'h100, 32'h3333_3333);
        chk("mis_b_exc_low", {31'd0, misalign_exc}, 32'd0);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        imem_rdata = 32'h4444_4444;
        step(); chk_issue("st1", 32'h100, 32'h3333_3333);
        branch_taken = 1'b0;
        step(); chk_issue("st2", 32'h100, 32'h3333_3333);
        branch_taken = 1'b1; branch_target = 32'h300;
        step(); chk_issue("st3", 32'h100, 32'h3333_3333);
        stall = 1'b0; branch_taken = 1'b0;
        step(); chk_fetch("st_rel", 32'h104);
        step(); chk_issue("st_rel_i", 32'h104, 32'h4444_4444);
        jalr_taken = 1'b1; jalr_target = 32'hFFFF_FFFD;
        step(); chk_fetch("wr_f", 32'hFFFF_FFFC);
        chk("wr_exc", {31'd0, misalign_exc}, 32'd0);
        jalr_taken = 1'b0;
        step(); chk_issue("wr_i", 32'hFFFF_FFFC, 32'h4444_4444);
        step(); chk_fetch("wrap", 32'h0);
        step(); chk_issue("wrap_i", 32'h0, 32'h4444_4444);
        branch_taken = 1'b1; branch_target = 32'h80; imem_ack = 1'b0;
        step(); chk_fetch("rf", 32'h80);
        branch_taken = 1'b0;
        step(); chk_fetch("rf_wait", 32'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_pc", pc, 32'h0);
        step();
        chk("late_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        rst_n = 1'b1;
        step(); chk_fetch("rs_f", 32'h0);
        chk("rs_instr", instr, 32'h0000_0013);
        imem_ack = 1'b0;
        step(); chk_fetch("rs_wait", 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
        step(); chk_issue("rs_i", 32'h0, 32'h6666_6666);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
